// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter over a tx_dv/tx_done handshake.
// Optional UART_FIFO_CRLF_EN: sends an extra 0x0A after every 0x0D byte.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                ICE_CLK,
  input  logic                rst,
  input  logic                rx_dv,
  input  logic [7:0]          rx_byte,
  input  logic                tx_done,
  output logic                tx_dv,
  output logic [7:0]          tx_byte,
  output logic [DEPTH_LOG2:0] level,
  output logic                empty,
  output logic                full,
  output logic                overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_ACK   = 3'd2;
  localparam logic [2:0] S_BUSY  = 3'd3;
`ifdef UART_FIFO_CRLF_EN
  localparam logic [2:0] S_LF    = 3'd4;
`endif

  logic [7:0]          mem [DEPTH];
  logic [7:0]          rd_data;
  logic [DEPTH_LOG2:0] wptr, rptr;
  logic [2:0]          state;
  logic                push, pop;

  // Extra pointer MSB distinguishes full from empty when the address bits match.
  assign empty = (wptr == rptr);
  assign full  = (wptr[DEPTH_LOG2-1:0] == rptr[DEPTH_LOG2-1:0]) &&
                 (wptr[DEPTH_LOG2] != rptr[DEPTH_LOG2]);
  assign level = wptr - rptr;

  assign push = rx_dv && !full;
  assign pop  = (state == S_IDLE) && !empty && tx_done;

  always_ff @(posedge ICE_CLK) begin
    if (push) mem[wptr[DEPTH_LOG2-1:0]] <= rx_byte;
  end

  always_ff @(posedge ICE_CLK) begin
    if (pop) rd_data <= mem[rptr[DEPTH_LOG2-1:0]];
  end

  always_ff @(posedge ICE_CLK) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (rx_dv && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge ICE_CLK) begin
    if (rst) begin
      state   <= S_IDLE;
      tx_dv   <= 1'b0;
      tx_byte <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          tx_dv <= 1'b0;
          if (pop) state <= S_FETCH;
        end
        S_FETCH: begin
          tx_byte <= rd_data;
          tx_dv   <= 1'b1;
          state   <= S_ACK;
        end
        // Hold here until the transmitter acknowledges by dropping tx_done.
        S_ACK: begin
          tx_dv <= 1'b0;
          if (!tx_done) state <= S_BUSY;
        end
        S_BUSY: begin
          tx_dv <= 1'b0;
`ifdef UART_FIFO_CRLF_EN
          if (tx_done) state <= (tx_byte == 8'h0D) ? S_LF : S_IDLE;
`else
          if (tx_done) state <= S_IDLE;
`endif
        end
`ifdef UART_FIFO_CRLF_EN
        S_LF: begin
          tx_byte <= 8'h0A;
          tx_dv   <= 1'b1;
          state   <= S_ACK;
        end
`endif
        default: begin
          tx_dv <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo (DEPTH_LOG2=2) with a modelled transmitter.
module tb_uart_tx_fifo;
  localparam int DL = 2;

  logic          ICE_CLK = 1'b0;
  logic          rst, rx_dv, tx_done, tx_dv, empty, full, overflow;
  logic [7:0]    rx_byte, tx_byte;
  logic [DL:0]   level;

  int            n_cmp = 0, n_err = 0;
  int            pulses = 0, pushed = 0;
  int            busy_cnt = 0, tx_cycles = 5;
  logic          tx_hold = 1'b0;
  logic [7:0]    sb[$];

  uart_tx_fifo #(.DEPTH_LOG2(DL)) dut (
    .ICE_CLK(ICE_CLK), .rst(rst), .rx_dv(rx_dv), .rx_byte(rx_byte),
    .tx_done(tx_done), .tx_dv(tx_dv), .tx_byte(tx_byte), .level(level),
    .empty(empty), .full(full), .overflow(overflow));

  always #5 ICE_CLK = ~ICE_CLK;

  // Transmitter: drops tx_done the cycle after tx_dv, busy for tx_cycles.
  always @(posedge ICE_CLK) begin
    if (tx_dv) busy_cnt <= tx_cycles;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_done = (busy_cnt == 0) && !tx_hold;

  always @(negedge ICE_CLK) begin
    if (tx_dv) begin
      pulses++;
      n_cmp++;
      if (!tx_done) begin
        n_err++;
        $display("FAIL pulse_while_busy: tx_dv=1 with tx_done=%0b, required tx_done=1", tx_done);
      end
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_tx: got byte %02h, required no pulse", tx_byte);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        if (tx_byte !== e) begin
          n_err++;
          $display("FAIL tx_byte_order: got %02h, required %02h", tx_byte, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge ICE_CLK); #1;
  endtask

  task automatic push(input logic [7:0] b, input bit accept);
    rx_dv = 1'b1; rx_byte = b; pushed++;
    if (accept) begin
      sb.push_back(b);
`ifdef UART_FIFO_CRLF_EN
      if (b == 8'h0D) sb.push_back(8'h0A);
`endif
    end
    tick();
    rx_dv = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((sb.size() != 0 || !tx_done || !empty) && t < 3000) begin tick(); t++; end
    repeat (6) tick();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: %0d bytes outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({tx_dv, tx_byte, level, empty, full, overflow} !== {1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: dv=%0b byte=%02h lvl=%0d e=%0b f=%0b o=%0b, required 0 00 0 1 0 0",
               tx_dv, tx_byte, level, empty, full, overflow);
    end
  endtask

  task automatic test_single();
    tx_cycles = 5;
    push(8'h41, 1'b1);
    n_cmp++;
    if (level !== 3'd1 || empty !== 1'b0) begin
      n_err++; $display("FAIL single_level: lvl=%0d empty=%0b, required 1 0", level, empty);
    end
    tick();
    n_cmp++;
    if (tx_dv !== 1'b0) begin
      n_err++; $display("FAIL single_early: tx_dv=%0b at N+2, required 0", tx_dv);
    end
    tick();
    n_cmp++;
    if (tx_dv !== 1'b1 || tx_byte !== 8'h41) begin
      n_err++; $display("FAIL single_latency: tx_dv=%0b byte=%02h at N+3, required 1 41", tx_dv, tx_byte);
    end
    n_cmp++;
    if (level !== 3'd0 || empty !== 1'b1) begin
      n_err++; $display("FAIL single_empty: lvl=%0d empty=%0b, required 0 1", level, empty);
    end
    drain("single");
  endtask

  task automatic test_burst();
    int t;
    tx_cycles = 20;
    for (int i = 1; i <= 16; i++) begin
      t = 0;
      while (pushed - pulses >= 4 && t < 200) begin tick(); t++; end
      push(i[7:0], 1'b1);
    end
    drain("burst");
  endtask

  task automatic test_full();
    tx_cycles = 4;
    tx_hold = 1'b1;
    for (int i = 0; i < 4; i++) push(8'h51 + i[7:0], 1'b1);
    n_cmp++;
    if (full !== 1'b1 || level !== 3'd4 || overflow !== 1'b0) begin
      n_err++; $display("FAIL full_after4: f=%0b lvl=%0d o=%0b, required 1 4 0", full, level, overflow);
    end
    push(8'h55, 1'b0);
    n_cmp++;
    if (overflow !== 1'b1 || level !== 3'd4) begin
      n_err++; $display("FAIL overflow_set: o=%0b lvl=%0d, required 1 4", overflow, level);
    end
    tx_hold = 1'b0;
    drain("full");
    n_cmp++;
    if (overflow !== 1'b1 || empty !== 1'b1) begin
      n_err++; $display("FAIL overflow_sticky: o=%0b e=%0b, required 1 1", overflow, empty);
    end
    rst = 1'b1; tick(); rst = 1'b0; tick();
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_err++; $display("FAIL overflow_clear: o=%0b, required 0", overflow);
    end
  endtask

  task automatic test_wrap();
    int p0, t;
    tx_cycles = 3;
    for (int i = 0; i < 10; i++) begin
      p0 = pulses;
      push(8'hA0 + i[7:0], 1'b1);
      t = 0;
      while ((pulses == p0 || !tx_done) && t < 100) begin
        n_cmp++;
        if (level > 3'd1) begin
          n_err++; $display("FAIL wrap_level: lvl=%0d, required <=1", level);
        end
        tick(); t++;
      end
    end
    drain("wrap");
  endtask

  task automatic test_reset_mid();
    int p0;
    tx_hold = 1'b1;
    for (int i = 0; i < 3; i++) push(8'hC0 + i[7:0], 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++;
    if (level !== 3'd0 || tx_dv !== 1'b0 || tx_byte !== 8'h00 || empty !== 1'b1) begin
      n_err++; $display("FAIL reset_mid: lvl=%0d dv=%0b byte=%02h e=%0b, required 0 0 00 1",
                        level, tx_dv, tx_byte, empty);
    end
    p0 = pulses;
    tx_hold = 1'b0;
    repeat (30) tick();
    n_cmp++;
    if (pulses != p0) begin
      n_err++; $display("FAIL reset_mid_quiet: %0d pulses after reset, required 0", pulses - p0);
    end
    push(8'h77, 1'b1);
    drain("reset_mid");
  endtask

  task automatic test_crlf();
    tx_cycles = 6;
    push(8'h0D, 1'b1);
    push(8'h42, 1'b1);
    push(8'h0A, 1'b1);
    drain("crlf");
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_full();
    test_wrap();
    test_reset_mid();
    test_crlf();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
